sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Shares one single-ported asynchronous SRAM between the CPU's instruction-fetch port and data-memory (load/store) port. Sits between `cpu` and the board SRAM pins. It arbitrates, sequences each access through a fixed multi-cycle SRAM timing, returns data with a one-cycle acknowledge pulse, and raises a stall request to the pipeline controller while any request is outstanding.

## Interface
- `ADDR_WIDTH`, 20, SRAM word-address width.
- `WAIT_CYCLES`, 1, extra SRAM access cycles beyond the first; legal range 1..15.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch request; held until `if_ack`.
- `if_addr`  in  32  fetch byte address, word-aligned.
- `if_rdata`  out  32  fetched word; valid when `if_ack`=1, held until the next `if_ack`.
- `if_ack`  out  1  one-cycle completion pulse.
- `mem_req`  in  1  data request; held until `mem_ack`.
- `mem_we`  in  1  1 = write, 0 = read.
- `mem_be`  in  4  active-high byte enables for writes.
- `mem_addr`  in  32  data byte address.
- `mem_wdata`  in  32  write data.
- `mem_rdata`  out  32  read data; valid when `mem_ack`=1, held until the next `mem_ack`.
- `mem_ack`  out  1  one-cycle completion pulse.
- `stall_req`  out  1  `(if_req & ~if_ack) | (mem_req & ~mem_ack)`; combinational.
- `sram_addr`  out  ADDR_WIDTH  word address, `addr[ADDR_WIDTH+1:2]`.
- `sram_wdata`  out  32  write data to the pad tristate.
- `sram_data_oe`  out  1  1 = top level drives `sram_wdata` onto the bus.
- `sram_rdata`  in  32  bus value from the pads.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`  out  1 each  active-low strobes.
- `sram_be_n`  out  4  active-low byte enables.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - If `mem_req`=1, grant MEM. Otherwise, if `if_req`=1, grant IF.
  - On a grant, latch the owner, address, we, be and wdata; load `cnt`=WAIT_CYCLES; go to ACCESS.
- **ACCESS**
  - Drive `ce_n`=0 and `sram_addr` from the latched address.
  - Read: `oe_n`=0, `we_n`=1, `be_n`=0000, `data_oe`=0.
  - Write: `oe_n`=1, `be_n`=~be, `data_oe`=1, `we_n`=0 in every ACCESS cycle except the last, where `we_n`=1 (address/data hold).
  - When `cnt`≠0, decrement it. When `cnt`=0, latch `sram_rdata` into the owner's rdata register (read only) and go to RESP.
- **RESP**
  - Assert the owner's ack for exactly this cycle; all strobes are inactive.
  - Always go to IDLE. The requester's `req` is still high here, so the block never re-samples it.
- Write transactions do not modify rdata registers.
- Requests arriving during ACCESS/RESP are not dropped; they stay pending and are granted in a later IDLE.
- Reset values: all strobes 1, `be_n`=1111, `data_oe`=0, both acks 0, both rdata 0, `sram_addr`/`sram_wdata` 0, state IDLE.

## Timing
- Request first sampled high in IDLE at cycle N.
  - ACCESS occupies cycles N+1 .. N+1+WAIT_CYCLES.
  - RESP (ack) is at cycle N+2+WAIT_CYCLES. With the default, ack comes 3 cycles after the request.
- Minimum back-to-back spacing: IDLE→ACCESS×(W+1)→RESP→IDLE, i.e. WAIT_CYCLES+3 cycles per transaction.
- `sram_rdata` is sampled at the clock edge ending the last ACCESS cycle.
- Simultaneous `if_req` and `mem_req` in IDLE: MEM is served first, then IF, with IDLE between them.
- Reset asserted mid-ACCESS: at the next edge the state is IDLE and all strobes are inactive. No ack is issued and rdata returns to 0. A partial write is allowed.
- `stall_req` is low in the ack cycle if the other port is idle.

## Configuration
- `SRAM_ARB_ROUND_ROBIN_EN` defined:
  - A 1-bit last-grant register (reset: IF).
  - On a simultaneous request in IDLE, the port *not* last granted wins.
  - A single requester always wins.
- Undefined: fixed MEM-over-IF priority as above, and no last-grant register.

## Test plan
- **Read fetch:** preload SRAM word 0x00010 = 0x3402_0001; `if_req`, `if_addr`=0x0000_0040.
  - `sram_addr`=0x00010, `oe_n`=0 for 2 cycles.
  - `if_ack` is high for 1 cycle exactly 3 cycles after the request, with `if_rdata`=0x3402_0001.
  - `stall_req`=1 for 3 cycles.
- **Byte write:** `mem_we`=1, `mem_be`=0010, `mem_addr`=0x0000_0008, `mem_wdata`=0xAABB_CCDD.
  - `we_n`=0 only in the first ACCESS cycle, `be_n`=1101.
  - A later read of 0x8 returns 0x0000_CC00 over a zero-initialised SRAM.
  - `mem_ack` arrives at N+3; `mem_rdata` is unchanged.
- **Collision:** both requests raised in the same cycle.
  - Without the macro: `mem_ack` at N+3, `if_ack` at N+7.
  - With `SRAM_ARB_ROUND_ROBIN_EN` and a previous MEM grant: IF is acked first.
- **Reset mid-access:** `rst`=1 in the second ACCESS cycle.
  - Next cycle: all strobes 1, `data_oe`=0, no ack ever pulses, both rdata = 0.
  - After reset drops, a held request completes normally.
- **WAIT_CYCLES=3:** a read acks 5 cycles after the request; back-to-back IF reads ack every 6 cycles.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-ported asynchronous SRAM between the CPU
// instruction-fetch port and the data (load/store) port. Each access runs
// IDLE -> ACCESS x (WAIT_CYCLES+1) -> RESP, with a one-cycle ack in RESP.
// Optional feature: define SRAM_ARB_ROUND_ROBIN_EN to alternate grants on
// simultaneous requests; otherwise MEM always has priority over IF.
module sram_arbiter #(
    parameter int ADDR_WIDTH  = 20,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    // instruction-fetch port
    input  logic                  if_req,
    input  logic [31:0]           if_addr,
    output logic [31:0]           if_rdata,
    output logic                  if_ack,
    // data port
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [3:0]            mem_be,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    output logic [31:0]           mem_rdata,
    output logic                  mem_ack,
    // pipeline stall
    output logic                  stall_req,
    // SRAM pins
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [31:0]           sram_wdata,
    output logic                  sram_data_oe,
    input  logic [31:0]           sram_rdata,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic [3:0]            sram_be_n
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic OWNER_IF  = 1'b0;
    localparam logic OWNER_MEM = 1'b1;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [3:0]            be_q, be_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [31:0]           if_rdata_q, if_rdata_d;
    logic [31:0]           mem_rdata_q, mem_rdata_d;

    logic                  grant_mem;
    logic                  unused_addr_bits;

    // Only the word-address bits reach the SRAM; the rest are ignored.
    assign unused_addr_bits = ^{if_addr[31:ADDR_WIDTH+2], if_addr[1:0],
                                mem_addr[31:ADDR_WIDTH+2], mem_addr[1:0]};

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;

    // MEM wins when alone, or on a collision if IF was granted last.
    always_comb begin
        grant_mem = mem_req & (~if_req | (last_grant_q == OWNER_IF));
    end

    // Last-grant register; reset favours MEM on the first collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= OWNER_IF;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    // Remember who was granted whenever a new access starts.
    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == ST_IDLE && (if_req || mem_req)) begin
            last_grant_d = grant_mem ? OWNER_MEM : OWNER_IF;
        end
    end
`else
    // Fixed priority: a pending data access always goes first.
    always_comb begin
        grant_mem = mem_req;
    end
`endif

    // State and transaction registers; reset returns to an idle bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWNER_IF;
            addr_q      <= '0;
            we_q        <= 1'b0;
            be_q        <= 4'h0;
            wdata_q     <= 32'h0;
            cnt_q       <= 4'h0;
            if_rdata_q  <= 32'h0;
            mem_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // Next-state: grant and latch in IDLE, count down in ACCESS, ack in RESP.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        we_d        = we_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (if_req || mem_req) begin
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = ST_ACCESS;
                    if (grant_mem) begin
                        owner_d = OWNER_MEM;
                        addr_d  = mem_addr[ADDR_WIDTH+1:2];
                        we_d    = mem_we;
                        be_d    = mem_be;
                        wdata_d = mem_wdata;
                    end else begin
                        owner_d = OWNER_IF;
                        addr_d  = if_addr[ADDR_WIDTH+1:2];
                        we_d    = 1'b0;
                        be_d    = 4'h0;
                        wdata_d = 32'h0;
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt_q != 4'h0) begin
                    cnt_d = cnt_q - 4'h1;
                end else begin
                    // Last access cycle: the read data is stable at this edge.
                    if (!we_q) begin
                        if (owner_q == OWNER_MEM) begin
                            mem_rdata_d = sram_rdata;
                        end else begin
                            if_rdata_d = sram_rdata;
                        end
                    end
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                // The requester still holds req here, so never re-sample it.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobe decode; the final write cycle releases we_n to hold addr/data.
    always_comb begin
        sram_ce_n    = 1'b1;
        sram_oe_n    = 1'b1;
        sram_we_n    = 1'b1;
        sram_be_n    = 4'hF;
        sram_data_oe = 1'b0;
        if_ack       = 1'b0;
        mem_ack      = 1'b0;
        case (state_q)
            ST_ACCESS: begin
                sram_ce_n = 1'b0;
                if (we_q) begin
                    sram_be_n    = ~be_q;
                    sram_data_oe = 1'b1;
                    sram_we_n    = (cnt_q == 4'h0);
                end else begin
                    sram_oe_n = 1'b0;
                    sram_be_n = 4'h0;
                end
            end
            ST_RESP: begin
                if_ack  = (owner_q == OWNER_IF);
                mem_ack = (owner_q == OWNER_MEM);
            end
            default: begin
            end
        endcase
    end

    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign if_rdata   = if_rdata_q;
    assign mem_rdata  = mem_rdata_q;
    assign stall_req  = (if_req & ~if_ack) | (mem_req & ~mem_ack);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed testbench for sram_arbiter: a default-timing instance exercising
// fetch, byte write, read-back, collision and reset-mid-access, plus a
// WAIT_CYCLES=3 instance for the longer access timing. Collision
// expectations follow SRAM_ARB_ROUND_ROBIN_EN when it is defined.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_init = 1'b1;

    // default-timing instance
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [3:0]  mem_be = 4'h0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall_req;
    logic [19:0] sram_addr;
    logic [31:0] sram_wdata;
    logic        sram_data_oe;
    logic [31:0] sram_rdata;
    logic        sram_ce_n, sram_oe_n, sram_we_n;
    logic [3:0]  sram_be_n;

    // WAIT_CYCLES=3 instance (fetch port only)
    logic        if_req3 = 1'b0;
    logic [31:0] if_addr3 = 32'h0;
    logic [31:0] if_rdata3;
    logic        if_ack3;
    logic        mem_req3 = 1'b0;
    logic        mem_we3 = 1'b0;
    logic [3:0]  mem_be3 = 4'h0;
    logic [31:0] mem_addr3 = 32'h0;
    logic [31:0] mem_wdata3 = 32'h0;
    logic [31:0] mem_rdata3;
    logic        mem_ack3;
    logic        stall_req3;
    logic [19:0] sram_addr3;
    logic [31:0] sram_wdata3;
    logic        sram_data_oe3;
    logic [31:0] sram_rdata3;
    logic        sram_ce_n3, sram_oe_n3, sram_we_n3;
    logic [3:0]  sram_be_n3;

    logic [31:0] sram_mem [0:255];

    int n_checks = 0;
    int n_fail   = 0;

    // per-transaction observations
    int          t_ack, t_stall, t_oe, t_doe;
    logic [31:0] t_we_mask;
    logic [3:0]  t_ben;
    logic [19:0] t_addr;
    logic [31:0] t_rdata;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_WIDTH(20), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_req(stall_req),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_data_oe(sram_data_oe),
        .sram_rdata(sram_rdata), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
    );

    sram_arbiter #(.ADDR_WIDTH(20), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst),
        .if_req(if_req3), .if_addr(if_addr3), .if_rdata(if_rdata3), .if_ack(if_ack3),
        .mem_req(mem_req3), .mem_we(mem_we3), .mem_be(mem_be3), .mem_addr(mem_addr3),
        .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .mem_ack(mem_ack3),
        .stall_req(stall_req3),
        .sram_addr(sram_addr3), .sram_wdata(sram_wdata3), .sram_data_oe(sram_data_oe3),
        .sram_rdata(sram_rdata3), .sram_ce_n(sram_ce_n3), .sram_oe_n(sram_oe_n3),
        .sram_we_n(sram_we_n3), .sram_be_n(sram_be_n3)
    );

    // Asynchronous SRAM model: reads only when selected and output-enabled.
    assign sram_rdata  = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[7:0]] : 32'hDEAD_BEEF;
    assign sram_rdata3 = (!sram_ce_n3 && !sram_oe_n3) ? sram_mem[sram_addr3[7:0]] : 32'hDEAD_BEEF;

    // Preload on mem_init; byte writes only while the bus is actually driven.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int k = 0; k < 256; k++) begin
                sram_mem[k] <= (k == 16) ? 32'h3402_0001 : 32'h0;
            end
        end else if (!sram_ce_n && !sram_we_n && sram_data_oe) begin
            for (int b = 0; b < 4; b++) begin
                if (!sram_be_n[b]) begin
                    sram_mem[sram_addr[7:0]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request on the default instance; records per-cycle observations.
    task automatic txn(input bit is_mem, input bit we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd);
        @(posedge clk); #1;
        if (is_mem) begin
            mem_req = 1'b1; mem_we = we; mem_be = be; mem_addr = addr; mem_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        t_ack = -1; t_stall = 0; t_oe = 0; t_doe = 0; t_we_mask = 32'h0;
        t_ben = 4'h0; t_addr = 20'h0; t_rdata = 32'h0;
        for (int i = 0; i < 12 && t_ack < 0; i++) begin
            @(negedge clk);
            if (stall_req)     t_stall++;
            if (!sram_oe_n)    t_oe++;
            if (sram_data_oe)  t_doe++;
            if (!sram_we_n)    t_we_mask[i] = 1'b1;
            if (i == 1) begin
                t_addr = sram_addr;
                t_ben  = sram_be_n;
            end
            if (is_mem ? mem_ack : if_ack) begin
                t_ack   = i;
                t_rdata = is_mem ? mem_rdata : if_rdata;
            end
        end
        @(posedge clk); #1;
        if (is_mem) mem_req = 1'b0; else if_req = 1'b0;
        $display("txn %s we=%0b addr=0x%08h ack_cycle=%0d rdata=0x%08h",
                 is_mem ? "MEM" : "IF", we, addr, t_ack, t_rdata);
    endtask

    initial begin : stim
        int tm, ti, stall3, early, ta, k;
        int          ack3 [0:2];
        logic [31:0] rd3  [0:2];
        logic [31:0] rd;
        logic        got;

        // reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_strobes", {29'h0, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);
        check_eq("rst_be_n", {28'h0, sram_be_n}, 32'hF);
        check_eq("rst_data_oe", {31'h0, sram_data_oe}, 32'h0);
        check_eq("rst_acks", {30'h0, if_ack, mem_ack}, 32'h0);
        check_eq("rst_if_rdata", if_rdata, 32'h0);
        check_eq("rst_mem_rdata", mem_rdata, 32'h0);
        check_eq("rst_sram_addr", {12'h0, sram_addr}, 32'h0);
        check_eq("rst_sram_wdata", sram_wdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_init = 1'b0;

        // read fetch
        txn(1'b0, 1'b0, 4'h0, 32'h0000_0040, 32'h0);
        check_eq("fetch_ack_cycle", t_ack, 32'd3);
        check_eq("fetch_rdata", t_rdata, 32'h3402_0001);
        check_eq("fetch_sram_addr", {12'h0, t_addr}, 32'h0001_0);
        check_eq("fetch_oe_cycles", t_oe, 32'd2);
        check_eq("fetch_stall_cycles", t_stall, 32'd3);

        // byte write
        txn(1'b1, 1'b1, 4'b0010, 32'h0000_0008, 32'hAABB_CCDD);
        check_eq("wr_ack_cycle", t_ack, 32'd3);
        check_eq("wr_we_mask", t_we_mask, 32'h2);
        check_eq("wr_be_n", {28'h0, t_ben}, 32'hD);
        check_eq("wr_data_oe_cycles", t_doe, 32'd2);
        check_eq("wr_mem_rdata_kept", t_rdata, 32'h0);

        // read back the written word
        txn(1'b1, 1'b0, 4'h0, 32'h0000_0008, 32'h0);
        check_eq("rdback_ack_cycle", t_ack, 32'd3);
        check_eq("rdback_rdata", t_rdata, 32'h0000_CC00);
        check_eq("rdback_if_rdata_held", if_rdata, 32'h3402_0001);

        // collision: MEM reads 0x40, IF reads 0x8
        @(posedge clk); #1;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0040;
        if_req = 1'b1; if_addr = 32'h0000_0008;
        tm = -1; ti = -1; stall3 = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i == 3) stall3 = stall_req ? 1 : 0;
            if (mem_ack && tm < 0) tm = i;
            if (if_ack && ti < 0) ti = i;
            @(posedge clk); #1;
            if (tm == i) mem_req = 1'b0;
            if (ti == i) if_req = 1'b0;
        end
        $display("txn COLLISION mem_ack_cycle=%0d if_ack_cycle=%0d", tm, ti);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        check_eq("coll_if_ack_cycle", ti, 32'd3);
        check_eq("coll_mem_ack_cycle", tm, 32'd7);
`else
        check_eq("coll_mem_ack_cycle", tm, 32'd3);
        check_eq("coll_if_ack_cycle", ti, 32'd7);
`endif
        check_eq("coll_stall_first_ack", stall3, 32'd1);
        check_eq("coll_mem_rdata", mem_rdata, 32'h3402_0001);
        check_eq("coll_if_rdata", if_rdata, 32'h0000_CC00);

        // WAIT_CYCLES=3: held fetch request, three back-to-back reads
        @(posedge clk); #1;
        if_req3 = 1'b1; if_addr3 = 32'h0000_0040;
        k = 0;
        for (int i = 0; i < 3; i++) begin
            ack3[i] = -1;
            rd3[i]  = 32'h0;
        end
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            got = 1'b0;
            if (if_ack3 && k < 3) begin
                ack3[k] = i;
                rd3[k]  = if_rdata3;
                k++;
                got = 1'b1;
            end
            @(posedge clk); #1;
            if (got && k == 1) if_addr3 = 32'h0000_0008;
            if (got && k == 3) if_req3 = 1'b0;
        end
        if_req3 = 1'b0;
        $display("txn W3 ack_cycles=%0d,%0d,%0d", ack3[0], ack3[1], ack3[2]);
        check_eq("w3_ack0_cycle", ack3[0], 32'd5);
        check_eq("w3_ack1_cycle", ack3[1], 32'd11);
        check_eq("w3_ack2_cycle", ack3[2], 32'd17);
        check_eq("w3_rdata0", rd3[0], 32'h3402_0001);
        check_eq("w3_rdata1", rd3[1], 32'h0000_CC00);

        // reset during the second ACCESS cycle of a MEM read
        @(posedge clk); #1;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0040;
        early = 0; ta = -1; rd = 32'h0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if ((mem_ack || if_ack) && i <= 3) early++;
            if (i == 3) begin
                check_eq("rstmid_strobes", {29'h0, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);
                check_eq("rstmid_data_oe", {31'h0, sram_data_oe}, 32'h0);
                check_eq("rstmid_be_n", {28'h0, sram_be_n}, 32'hF);
                check_eq("rstmid_mem_rdata", mem_rdata, 32'h0);
                check_eq("rstmid_if_rdata", if_rdata, 32'h0);
            end
            if (mem_ack && ta < 0) begin
                ta = i;
                rd = mem_rdata;
            end
            @(posedge clk); #1;
            if (i == 1) rst = 1'b1;
            if (i == 3) rst = 1'b0;
            if (ta == i) mem_req = 1'b0;
        end
        mem_req = 1'b0;
        $display("txn RSTMID ack_cycle=%0d rdata=0x%08h", ta, rd);
        check_eq("rstmid_no_early_ack", early, 32'd0);
        check_eq("rstmid_retry_ack_cycle", ta, 32'd7);
        check_eq("rstmid_retry_rdata", rd, 32'h3402_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
